// File: rtl/wdt_pkg.sv
// Shared types and constants for the multi-channel watchdog timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   WDT_STATE_W  width of the per-channel state register
//   wdt_state_t  per-channel FSM state encoding
package wdt_pkg;

  localparam int WDT_STATE_W = 2;

  typedef enum logic [WDT_STATE_W-1:0] {
    WDT_IDLE    = 2'd0,
    WDT_RUN     = 2'd1,
    WDT_EXPIRED = 2'd2
  } wdt_state_t;

endpackage : wdt_pkg

// File: rtl/wdt_channel.sv
// One watchdog channel: FSM plus tick counter with sticky expiry flag.
// Latency: expired/early_kick rise on the clk edge that samples the causing tick/kick.
// Backpressure: none; tick and kick are pulses consumed unconditionally.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tick         shared count-enable strobe
//   en           arm; 1 = channel may run
//   kick         service pulse; restarts the count
//   clear_flag   acknowledge of an expiry (only acts in EXPIRED)
//   timeout      expiry limit, sampled live
//   win          early-kick window (only with WDT_WINDOW_EN)
//   count        current count
//   expired      sticky expiry flag
//   early_kick   sticky "kicked too early" flag (tied 0 without WDT_WINDOW_EN)
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         en,
  input  logic         kick,
  input  logic         clear_flag,
  input  logic [W-1:0] timeout,
  input  logic [W-1:0] win,
  output logic [W-1:0] count,
  output logic         expired,
  output logic         early_kick
);

  wdt_state_t state;
  logic       early_hit;

`ifdef WDT_WINDOW_EN
  // A zero window disables the early-kick check entirely.
  assign early_hit = (win != '0) && (count < win);
`else
  logic unused_win;
  assign unused_win = ^win;
  assign early_hit  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WDT_IDLE;
      count      <= '0;
      expired    <= 1'b0;
      early_kick <= 1'b0;
    end else begin
      case (state)
        WDT_IDLE: begin
          count <= '0;
          if (en) state <= WDT_RUN;
        end

        // en=0 beats kick, kick beats tick.
        WDT_RUN: begin
          if (!en) begin
            state <= WDT_IDLE;
            count <= '0;
          end else if (kick) begin
            if (early_hit) begin
              state      <= WDT_EXPIRED;
              expired    <= 1'b1;
              early_kick <= 1'b1;
            end else begin
              count <= '0;
            end
          end else if (tick) begin
            // Equality compare: count never passes timeout, so the
            // increment can never wrap under a stable timeout. A timeout
            // lowered below count lets it run on and wrap by design.
            if (count == timeout) begin
              state   <= WDT_EXPIRED;
              expired <= 1'b1;
            end else begin
              count <= count + W'(1);
            end
          end
        end

        // Frozen until acknowledged; en, kick and tick are ignored.
        WDT_EXPIRED: begin
          if (clear_flag) begin
            state      <= WDT_IDLE;
            count      <= '0;
            expired    <= 1'b0;
            early_kick <= 1'b0;
          end
        end

        default: begin
          state <= WDT_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule : wdt_channel

// File: rtl/watchdog_timer.sv
// N-channel watchdog timer; slices flat buses onto wdt_channel instances.
// Latency: expired one edge after the expiring tick; any_expired one edge later.
// Backpressure: none.
//
// Optional feature macro: WDT_WINDOW_EN (windowed watchdog, early-kick fault).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tick         shared count-enable strobe
//   en/kick/clear_flag  per-channel controls [N]
//   timeout/win  per-channel limits, channel c at [c*W +: W]
//   count        per-channel counts, channel c at [c*W +: W]
//   expired/early_kick  per-channel sticky flags [N]
//   any_expired  registered OR of expired
module watchdog_timer
  import wdt_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic [N-1:0]   en,
  input  logic [N-1:0]   kick,
  input  logic [N-1:0]   clear_flag,
  input  logic [N*W-1:0] timeout,
  input  logic [N*W-1:0] win,
  output logic [N*W-1:0] count,
  output logic [N-1:0]   expired,
  output logic [N-1:0]   early_kick,
  output logic           any_expired
);

  for (genvar c = 0; c < N; c++) begin : g_ch
    wdt_channel #(.W(W)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .en         (en[c]),
      .kick       (kick[c]),
      .clear_flag (clear_flag[c]),
      .timeout    (timeout[c*W +: W]),
      .win        (win[c*W +: W]),
      .count      (count[c*W +: W]),
      .expired    (expired[c]),
      .early_kick (early_kick[c])
    );
  end

  // Registered so the fault controller sees a clean flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_expired <= 1'b0;
    else        any_expired <= |expired;
  end

endmodule : watchdog_timer

// File: tb/tb_watchdog_timer.sv
// Directed self-checking bench for watchdog_timer (W=8, N=4).
// Inputs change 1ns after posedge; outputs are checked at the same point.
// Expected values are hand-computed constants per step.
module tb_watchdog_timer;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           tick;
  logic [N-1:0]   en, kick, clear_flag;
  logic [N*W-1:0] timeout, win;
  logic [N*W-1:0] count;
  logic [N-1:0]   expired, early_kick;
  logic           any_expired;

  int passed = 0;
  int total  = 0;

  watchdog_timer #(.W(W), .N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .en          (en),
    .kick        (kick),
    .clear_flag  (clear_flag),
    .timeout     (timeout),
    .win         (win),
    .count       (count),
    .expired     (expired),
    .early_kick  (early_kick),
    .any_expired (any_expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  function automatic logic [31:0] cnt(input int c);
    return {24'd0, count[c*W +: W]};
  endfunction

  initial begin
    rst_n = 1'b0; tick = 1'b0;
    en = '0; kick = '0; clear_flag = '0;
    timeout = '0; win = '0;
    step(); step();

    // Reset state
    chk("rst_count",  count,       '0);
    chk("rst_exp",    expired,     '0);
    chk("rst_early",  early_kick,  '0);
    chk("rst_any",    any_expired, 1'b0);
    rst_n = 1'b1;
    step();

    // 1: ch0 timeout=5, expiry on 6th tick, any_expired one cycle later
    timeout[0*W +: W] = 8'd5;
    en[0] = 1'b1;
    step();
    chk("t1_arm_cnt", cnt(0), 0);
    for (int i = 1; i <= 5; i++) begin
      ticks(1);
      chk($sformatf("t1_cnt%0d", i), cnt(0), i);
    end
    chk("t1_noexp5", expired[0], 1'b0);
    ticks(1);
    chk("t1_exp",     expired[0],  1'b1);
    chk("t1_cnt_hold", cnt(0),     5);
    chk("t1_any_lag", any_expired, 1'b0);
    step();
    chk("t1_any",     any_expired, 1'b1);
    clear_flag[0] = 1'b1;
    step();
    clear_flag[0] = 1'b0;
    chk("t1_clr_exp", expired[0], 1'b0);
    chk("t1_clr_cnt", cnt(0),     0);

    // 2: kick beats tick in the same cycle (en still high -> re-arm)
    step();
    ticks(3);
    chk("t2_cnt3", cnt(0), 3);
    kick[0] = 1'b1; tick = 1'b1;
    step();
    kick[0] = 1'b0; tick = 1'b0;
    chk("t2_kick_cnt", cnt(0), 0);
    ticks(5);
    chk("t2_cnt5",   cnt(0),     5);
    chk("t2_noexp",  expired[0], 1'b0);
    ticks(1);
    chk("t2_exp",    expired[0], 1'b1);
    clear_flag[0] = 1'b1; en[0] = 1'b0;
    step();
    clear_flag[0] = 1'b0;

    // 3: ch1 expires, then en/kick/tick are ignored until clear_flag
    timeout[1*W +: W] = 8'd1;
    en[1] = 1'b1;
    step();
    ticks(1);
    chk("t3_cnt1", cnt(1), 1);
    ticks(1);
    chk("t3_exp",  expired[1], 1'b1);
    en[1] = 1'b0; kick[1] = 1'b1;
    ticks(2);
    kick[1] = 1'b0;
    chk("t3_frz_cnt", cnt(1),     1);
    chk("t3_frz_exp", expired[1], 1'b1);
    chk("t3_ch0_ind", expired[0], 1'b0);
    clear_flag[1] = 1'b1;
    step();
    clear_flag[1] = 1'b0;
    chk("t3_clr_cnt", cnt(1),     0);
    chk("t3_clr_exp", expired[1], 1'b0);
    step();
    chk("t3_any_low", any_expired, 1'b0);

    // 4: timeout=0 on ch2 (left expired), timeout=255 on ch3
    timeout[2*W +: W] = 8'd0;
    timeout[3*W +: W] = 8'd255;
    en[2] = 1'b1; en[3] = 1'b1;
    step();
    ticks(1);
    chk("t4_t0_exp", expired[2], 1'b1);
    chk("t4_t0_cnt", cnt(2),     0);
    ticks(254);
    chk("t4_cnt255", cnt(3),     255);
    chk("t4_noexp",  expired[3], 1'b0);
    ticks(1);
    chk("t4_exp255", expired[3], 1'b1);
    chk("t4_nowrap", cnt(3),     255);
    clear_flag[3] = 1'b1; en[3] = 1'b0;
    step();
    clear_flag[3] = 1'b0;

    // 5: async reset mid-RUN (ch0 count=4) with ch2 still EXPIRED
    timeout[0*W +: W] = 8'd10;
    en[0] = 1'b1;
    step();
    ticks(4);
    chk("t5_pre_cnt", cnt(0),     4);
    chk("t5_pre_exp", expired[2], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_cnt",   count,       '0);
    chk("t5_exp",   expired,     '0);
    chk("t5_early", early_kick,  '0);
    chk("t5_any",   any_expired, 1'b0);
    en = '0;
    step();
    rst_n = 1'b1;
    step();

    // 6: window on ch3 (win=4); early kick faults only with WDT_WINDOW_EN
    timeout[3*W +: W] = 8'd20;
    win[3*W +: W] = 8'd4;
    en[3] = 1'b1;
    step();
    ticks(2);
    chk("t6_cnt2", cnt(3), 2);
    kick[3] = 1'b1;
    step();
    kick[3] = 1'b0;
`ifdef WDT_WINDOW_EN
    chk("t6_early_exp", expired[3],    1'b1);
    chk("t6_early_flg", early_kick[3], 1'b1);
    chk("t6_early_cnt", cnt(3),        2);
`else
    chk("t6_nowin_exp", expired[3],    1'b0);
    chk("t6_nowin_flg", early_kick[3], 1'b0);
    chk("t6_nowin_cnt", cnt(3),        0);
`endif
    clear_flag[3] = 1'b1;
    step();
    clear_flag[3] = 1'b0;
    step();
    chk("t6_clr_cnt",   cnt(3),        0);
    chk("t6_clr_early", early_kick[3], 1'b0);
    ticks(4);
    chk("t6_cnt4", cnt(3), 4);
    kick[3] = 1'b1;
    step();
    kick[3] = 1'b0;
    chk("t6_ok_cnt",   cnt(3),        0);
    chk("t6_ok_exp",   expired[3],    1'b0);
    chk("t6_ok_early", early_kick[3], 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_watchdog_timer
